// File: rtl/muxn_fifo.sv
// muxn_fifo: N:1 signed channel selector feeding a valid/ready registered output queue.
// Optional build macro MUXN_FIFO_SEL_ERR_EN adds sticky sel_err and drops out-of-range pushes.
// Ports: Clk, Reset_n (async active-low); Din (NUM_INPUTS packed words), select, mode (0 ext, 1 round-robin),
//        in_valid/in_ready request handshake; Dout, Dout_sel, out_valid/out_ready queue head handshake.
module muxn_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_WIDTH  = $clog2(NUM_INPUTS),
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             Clk,
  input  logic                             Reset_n,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] Din,
  input  logic [SEL_WIDTH-1:0]             select,
  input  logic                             mode,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic signed [DATA_WIDTH-1:0]     Dout,
  output logic [SEL_WIDTH-1:0]             Dout_sel,
  output logic                             out_valid,
  input  logic                             out_ready
`ifdef MUXN_FIFO_SEL_ERR_EN
  ,
  output logic                             sel_err
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NL = NUM_INPUTS - 1;
  localparam logic [SEL_WIDTH-1:0] LAST = NL[SEL_WIDTH-1:0];
  localparam logic [PW:0] FULL = FIFO_DEPTH[PW:0];
  logic signed [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [SEL_WIDTH-1:0] mem_sel [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0] count_q, count_d;
  logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d, idx;
  logic signed [DATA_WIDTH-1:0] word;
  logic push, wr, pop;
`ifdef MUXN_FIFO_SEL_ERR_EN
  localparam logic [SEL_WIDTH:0] NI = NUM_INPUTS[SEL_WIDTH:0];
  logic in_range, sel_err_q, sel_err_d;
  assign sel_err = sel_err_q;
`endif
  always_comb begin
    idx = mode ? rr_ptr_q : select;
    // an index with no matching channel leaves the word at zero
    word = '0;
    for (int k = 0; k < NUM_INPUTS; k++)
      if (idx == k[SEL_WIDTH-1:0]) word = Din[k*DATA_WIDTH +: DATA_WIDTH];
    in_ready = count_q != FULL;
    out_valid = count_q != '0;
    push = in_valid && in_ready;
`ifdef MUXN_FIFO_SEL_ERR_EN
    in_range = {1'b0, idx} < NI;
    wr = push && in_range;
    sel_err_d = sel_err_q | (push && !mode && !in_range);
`else
    wr = push;
`endif
    pop = out_valid && out_ready;
    wr_ptr_d = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = count_q + {{PW{1'b0}}, wr} - {{PW{1'b0}}, pop};
    rr_ptr_d = (push && mode) ? (rr_ptr_q == LAST ? '0 : rr_ptr_q + 1'b1) : rr_ptr_q;
    Dout = out_valid ? mem_data[rd_ptr_q] : '0;
    Dout_sel = out_valid ? mem_sel[rd_ptr_q] : '0;
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      rr_ptr_q <= '0;
`ifdef MUXN_FIFO_SEL_ERR_EN
      sel_err_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef MUXN_FIFO_SEL_ERR_EN
      sel_err_q <= sel_err_d;
`endif
    end
  // storage needs no reset: count gates every read
  always_ff @(posedge Clk)
    if (wr) begin
      mem_data[wr_ptr_q] <= word;
      mem_sel[wr_ptr_q] <= idx;
    end
endmodule
